// File: rtl/gc_tx_scheduler.sv
// Garbler transmit scheduler: merges keys, input labels, garbled-table pairs and packed
// output-mask words into one tagged valid/ready stream behind a single output register.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_KEYS  | waiting to emit the R / AES key beat (fin is remembered here)
// ST_RUN   | arbitrating labels > mask word > GT pairs
// ST_FLUSH | draining labels, pending mask word, GT FIFO, partial mask word
// ST_DONE  | one-cycle done pulse, then back to idle
module gc_tx_scheduler #(
    parameter int S = 20,
    parameter int K = 128,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         fin,
    input  logic         key_valid,
    input  logic [K-1:0] key_R,
    input  logic [K-1:0] key_aes,
    output logic         key_ready,
    input  logic [1:0]   lbl_valid,
    input  logic [S-1:0] lbl_index0,
    input  logic [S-1:0] lbl_index1,
    input  logic [K-1:0] lbl_data0,
    input  logic [K-1:0] lbl_data1,
    output logic         lbl_ready,
    input  logic         gt_wr,
    input  logic [K-1:0] gt_t0,
    input  logic [K-1:0] gt_t1,
    output logic         gt_full,
    input  logic         mask_valid,
    input  logic         mask_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2:0]   tag,
    output logic [S-1:0] index0,
    output logic [S-1:0] index1,
    output logic [K-1:0] data0,
    output logic [K-1:0] data1,
    output logic         done,
    output logic         overflow
);

    localparam int W     = 2 * K;
    localparam int MB    = $clog2(W);
    localparam int DEPTH = 2 ** D;

    localparam logic [2:0] TAG_IDLE = 3'b000;
    localparam logic [2:0] TAG_KEY  = 3'b001;
    localparam logic [2:0] TAG_GT   = 3'b010;
    localparam logic [2:0] TAG_MASK = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYS,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t state;
    logic   fin_pend;

    logic [2*K-1:0] gt_mem [DEPTH];
    logic [D-1:0]   gt_wr_ptr;
    logic [D-1:0]   gt_rd_ptr;
    logic [D:0]     gt_count;
    logic [S-1:0]   gt_seq;
    logic [2*K-1:0] gt_head;

    logic [W-1:0]  mask_acc;
    logic [W-1:0]  mask_acc_nxt;
    logic [W-1:0]  mask_word;
    logic [MB-1:0] mask_cnt;
    logic          mask_pend;
    logic [S-1:0]  mask_num;

    logic can_load, active, session_start;
    logic sel_key, sel_lbl, sel_mask, sel_gt, sel_part;
    logic gt_push, gt_pop, gt_empty;
    logic mask_in, mask_wrap, flush_idle;

    assign can_load      = !out_valid || out_ready;
    assign active        = (state == ST_RUN) || (state == ST_FLUSH);
    assign session_start = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign gt_empty      = (gt_count == '0);
    assign gt_full       = (gt_count == (D+1)'(DEPTH));
    assign gt_head       = gt_mem[gt_rd_ptr];

    assign sel_key  = (state == ST_KEYS) && key_valid && can_load;
    assign sel_lbl  = active && (lbl_valid != 2'b00) && can_load;
    assign sel_mask = active && !sel_lbl && mask_pend && can_load;
    assign sel_gt   = active && !sel_lbl && !mask_pend && !gt_empty && can_load;
    assign sel_part = (state == ST_FLUSH) && !sel_lbl && !mask_pend && gt_empty
                      && (mask_cnt != '0) && can_load;

    assign key_ready = sel_key;
    assign lbl_ready = sel_lbl;

    assign gt_pop  = sel_gt;
    assign gt_push = gt_wr && (!gt_full || gt_pop);

    // Mask bits are only collected while the garbler can still be producing them.
    assign mask_in    = mask_valid && ((state == ST_KEYS) || (state == ST_RUN));
    assign mask_wrap  = mask_in && (mask_cnt == MB'(W - 1));
    assign flush_idle = !mask_pend && gt_empty && (mask_cnt == '0) && !out_valid
                        && (lbl_valid == 2'b00);

    always_comb begin
        mask_acc_nxt = mask_acc;
        if (mask_in) begin
            mask_acc_nxt[mask_cnt] = mask_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (gt_push) begin
            gt_mem[gt_wr_ptr] <= {gt_t1, gt_t0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gt_wr_ptr <= '0;
            gt_rd_ptr <= '0;
            gt_count  <= '0;
            gt_seq    <= '0;
            overflow  <= 1'b0;
            mask_acc  <= '0;
            mask_word <= '0;
            mask_cnt  <= '0;
            mask_pend <= 1'b0;
            mask_num  <= '0;
        end else begin
            if (gt_push) begin
                gt_wr_ptr <= gt_wr_ptr + D'(1);
            end
            if (gt_pop) begin
                gt_rd_ptr <= gt_rd_ptr + D'(1);
                gt_seq    <= gt_seq + S'(1);
            end
            case ({gt_push, gt_pop})
                2'b10:   gt_count <= gt_count + (D+1)'(1);
                2'b01:   gt_count <= gt_count - (D+1)'(1);
                default: gt_count <= gt_count;
            endcase
            if (gt_wr && gt_full && !gt_pop) begin
                overflow <= 1'b1;
            end

            if (sel_mask || sel_part) begin
                mask_num <= mask_num + S'(1);
            end
            if (session_start) begin
                gt_seq   <= '0;
                mask_num <= '0;
            end

            if (mask_wrap || sel_part) begin
                mask_acc <= '0;
                mask_cnt <= '0;
            end else if (mask_in) begin
                mask_acc <= mask_acc_nxt;
                mask_cnt <= mask_cnt + MB'(1);
            end
            // A word completing while the previous one is still waiting is dropped.
            if (mask_wrap && (!mask_pend || sel_mask)) begin
                mask_word <= mask_acc_nxt;
                mask_pend <= 1'b1;
            end else if (sel_mask) begin
                mask_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            fin_pend  <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            tag       <= TAG_IDLE;
            index0    <= '1;
            index1    <= '1;
            data0     <= '0;
            data1     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_KEYS;
                        fin_pend <= 1'b0;
                    end
                end
                ST_KEYS: begin
                    if (fin) begin
                        fin_pend <= 1'b1;
                    end
                    if (sel_key) begin
                        state <= (fin || fin_pend) ? ST_FLUSH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fin) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_idle) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state    <= start ? ST_KEYS : ST_IDLE;
                    fin_pend <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase

            if (sel_key) begin
                out_valid <= 1'b1;
                tag       <= TAG_KEY;
                index0    <= '1;
                index1    <= '1;
                data0     <= key_R;
                data1     <= key_aes;
            end else if (sel_lbl) begin
                out_valid <= 1'b1;
                tag       <= {1'b1, lbl_valid};
                index0    <= lbl_valid[0] ? lbl_index0 : '1;
                index1    <= lbl_valid[1] ? lbl_index1 : '1;
                data0     <= lbl_valid[0] ? lbl_data0 : '0;
                data1     <= lbl_valid[1] ? lbl_data1 : '0;
            end else if (sel_mask) begin
                out_valid <= 1'b1;
                tag       <= TAG_MASK;
                index0    <= mask_num;
                index1    <= '1;
                data0     <= mask_word[K-1:0];
                data1     <= mask_word[W-1:K];
            end else if (sel_gt) begin
                out_valid <= 1'b1;
                tag       <= TAG_GT;
                index0    <= {gt_seq[S-2:0], 1'b0};
                index1    <= {gt_seq[S-2:0], 1'b1};
                data0     <= gt_head[K-1:0];
                data1     <= gt_head[2*K-1:K];
            end else if (sel_part) begin
                out_valid <= 1'b1;
                tag       <= TAG_MASK;
                index0    <= mask_num;
                index1    <= '1;
                data0     <= mask_acc[K-1:0];
                data1     <= mask_acc[W-1:K];
            end else if (out_ready) begin
                out_valid <= 1'b0;
                tag       <= TAG_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_gc_tx_scheduler.sv
// Self-checking bench for gc_tx_scheduler: directed scenarios plus a randomized session
// checked per stream (labels, GT pairs, mask words) against a queue-based reference model.
module tb_gc_tx_scheduler;
    localparam int S  = 20;
    localparam int K  = 128;
    localparam int D  = 4;
    localparam int W  = 2 * K;
    localparam int BW = 3 + 2 * S + 2 * K;
    localparam logic [S-1:0] ONES = '1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, fin;
    logic         key_valid;
    logic [K-1:0] key_R, key_aes;
    logic         key_ready;
    logic [1:0]   lbl_valid;
    logic [S-1:0] lbl_index0, lbl_index1;
    logic [K-1:0] lbl_data0, lbl_data1;
    logic         lbl_ready;
    logic         gt_wr;
    logic [K-1:0] gt_t0, gt_t1;
    logic         gt_full;
    logic         mask_valid, mask_bit;
    logic         out_valid, out_ready;
    logic [2:0]   tag;
    logic [S-1:0] index0, index1;
    logic [K-1:0] data0, data1;
    logic         done, overflow;

    always #5 clk = ~clk;

    gc_tx_scheduler #(.S(S), .K(K), .D(D)) dut (
        .clk(clk), .rst(rst), .start(start), .fin(fin),
        .key_valid(key_valid), .key_R(key_R), .key_aes(key_aes), .key_ready(key_ready),
        .lbl_valid(lbl_valid), .lbl_index0(lbl_index0), .lbl_index1(lbl_index1),
        .lbl_data0(lbl_data0), .lbl_data1(lbl_data1), .lbl_ready(lbl_ready),
        .gt_wr(gt_wr), .gt_t0(gt_t0), .gt_t1(gt_t1), .gt_full(gt_full),
        .mask_valid(mask_valid), .mask_bit(mask_bit),
        .out_valid(out_valid), .out_ready(out_ready), .tag(tag),
        .index0(index0), .index1(index1), .data0(data0), .data1(data1),
        .done(done), .overflow(overflow)
    );

    typedef struct {
        logic [2:0]   tag;
        logic [S-1:0] i0;
        logic [S-1:0] i1;
        logic [K-1:0] d0;
        logic [K-1:0] d1;
    } beat_t;

    beat_t        obs[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [S-1:0] gt_seq_m;

    // Every beat the sink takes, in order.
    always @(negedge clk) begin
        beat_t b;
        if (rst && out_valid && out_ready) begin
            b.tag = tag; b.i0 = index0; b.i1 = index1; b.d0 = data0; b.d1 = data1;
            obs.push_back(b);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [K-1:0] rnd_k();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [BW-1:0] pk(beat_t b);
        return {b.tag, b.i0, b.i1, b.d0, b.d1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; fin = 0; key_valid = 0; lbl_valid = 2'b00; gt_wr = 0; mask_valid = 0;
        mask_bit = 0; key_R = '0; key_aes = '0; lbl_index0 = '0; lbl_index1 = '0;
        lbl_data0 = '0; lbl_data1 = '0; gt_t0 = '0; gt_t1 = '0;
    endtask

    task automatic send_keys(input logic [K-1:0] r, input logic [K-1:0] a, output int hi);
        bit acc;
        acc = 0;
        hi = 0;
        key_R = r; key_aes = a; key_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (key_ready) begin hi++; acc = 1; end
            tick();
        end
        key_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (key_ready) hi++;
            tick();
        end
    endtask

    task automatic wait_done(input int budget, output int pulses);
        pulses = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) pulses++;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [2*S+8:0] got, want;
        want = {1'b0, 3'b000, ONES, ONES, 5'b00000};
        rst = 1'b0;
        idle_inputs();
        out_ready = 1'b0;
        repeat (3) tick();
        got = {out_valid, tag, index0, index1, done, overflow, key_ready, lbl_ready, gt_full};
        n_cmp++;
        if (got !== want) begin n_err++; $display("FAIL reset_ctrl: got %h want %h", got, want); end
        n_cmp++;
        if ({data0, data1} !== '0) begin
            n_err++; $display("FAIL reset_data: got %h %h want 0", data0, data1);
        end
        rst = 1'b1;
        repeat (2) tick();
        got = {out_valid, tag, index0, index1, done, overflow, key_ready, lbl_ready, gt_full};
        n_cmp++;
        if (got !== want) begin n_err++; $display("FAIL idle_ctrl: got %h want %h", got, want); end
    endtask

    task automatic test_keys();
        int hi;
        beat_t e;
        obs.delete();
        gt_seq_m = '0;
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        send_keys(128'h1, {16{8'hA5}}, hi);
        n_cmp++;
        if (hi != 1) begin n_err++; $display("FAIL key_ready_cycles: got %0d want 1", hi); end
        n_cmp++;
        if (obs.size() != 1) begin n_err++; $display("FAIL key_beats: got %0d want 1", obs.size()); end
        else begin
            e.tag = 3'b001; e.i0 = ONES; e.i1 = ONES; e.d0 = 128'h1; e.d1 = {16{8'hA5}};
            n_cmp++;
            if (pk(obs[0]) !== pk(e)) begin
                n_err++; $display("FAIL key_beat: got %h want %h", pk(obs[0]), pk(e));
            end
        end
    endtask

    task automatic test_gt_stall();
        logic [K-1:0] t0[3], t1[3];
        logic [BW-1:0] want;
        beat_t e;
        obs.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            t0[i] = rnd_k(); t1[i] = rnd_k();
            gt_t0 = t0[i]; gt_t1 = t1[i]; gt_wr = 1'b1;
            tick();
        end
        gt_wr = 1'b0;
        want = {3'b010, S'(2 * gt_seq_m), S'(2 * gt_seq_m + 1), t0[0], t1[0]};
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (!out_valid || {tag, index0, index1, data0, data1} !== want) begin
            n_err++; $display("FAIL stall_first: valid %b got %h want %h", out_valid,
                              {tag, index0, index1, data0, data1}, want);
        end
        repeat (4) tick();
        @(negedge clk);
        n_cmp++;
        if (!out_valid || {tag, index0, index1, data0, data1} !== want) begin
            n_err++; $display("FAIL stall_hold: valid %b got %h want %h", out_valid,
                              {tag, index0, index1, data0, data1}, want);
        end
        tick();
        out_ready = 1'b1;
        repeat (8) tick();
        n_cmp++;
        if (obs.size() != 3) begin n_err++; $display("FAIL stall_count: got %0d want 3", obs.size()); end
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            e.tag = 3'b010; e.i0 = S'(2 * (gt_seq_m + i)); e.i1 = S'(2 * (gt_seq_m + i) + 1);
            e.d0 = t0[i]; e.d1 = t1[i];
            n_cmp++;
            if (pk(obs[i]) !== pk(e)) begin
                n_err++; $display("FAIL stall_beat%0d: got %h want %h", i, pk(obs[i]), pk(e));
            end
        end
        gt_seq_m = gt_seq_m + S'(3);
    endtask

    task automatic test_label_priority();
        beat_t el, eg;
        obs.delete();
        out_ready = 1'b1;
        lbl_valid = 2'b01;
        lbl_index0 = S'($urandom); lbl_index1 = S'($urandom);
        lbl_data0 = rnd_k(); lbl_data1 = rnd_k();
        gt_t0 = rnd_k(); gt_t1 = rnd_k(); gt_wr = 1'b1;
        el.tag = 3'b101; el.i0 = lbl_index0; el.i1 = ONES; el.d0 = lbl_data0; el.d1 = '0;
        eg.tag = 3'b010; eg.i0 = S'(2 * gt_seq_m); eg.i1 = S'(2 * gt_seq_m + 1);
        eg.d0 = gt_t0; eg.d1 = gt_t1;
        @(negedge clk);
        n_cmp++;
        if (lbl_ready !== 1'b1) begin n_err++; $display("FAIL lbl_ready: got %b want 1", lbl_ready); end
        tick();
        lbl_valid = 2'b00; gt_wr = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (obs.size() != 2) begin n_err++; $display("FAIL prio_count: got %0d want 2", obs.size()); end
        else begin
            n_cmp++;
            if (pk(obs[0]) !== pk(el)) begin
                n_err++; $display("FAIL prio_label: got %h want %h", pk(obs[0]), pk(el));
            end
            n_cmp++;
            if (pk(obs[1]) !== pk(eg)) begin
                n_err++; $display("FAIL prio_gt: got %h want %h", pk(obs[1]), pk(eg));
            end
        end
        gt_seq_m = gt_seq_m + S'(1);
    endtask

    task automatic test_mask();
        int pulses;
        beat_t e0, e1;
        obs.delete();
        out_ready = 1'b1;
        for (int n = 0; n < 260; n++) begin
            mask_valid = 1'b1;
            mask_bit = (n % 2 == 0);
            fin = (n == 259);
            tick();
        end
        mask_valid = 1'b0; fin = 1'b0;
        wait_done(60, pulses);
        e0.tag = 3'b011; e0.i0 = S'(0); e0.i1 = ONES; e0.d0 = {32{4'h5}}; e0.d1 = {32{4'h5}};
        e1.tag = 3'b011; e1.i0 = S'(1); e1.i1 = ONES; e1.d0 = 128'h5;     e1.d1 = '0;
        n_cmp++;
        if (pulses != 1) begin n_err++; $display("FAIL mask_done: got %0d pulses want 1", pulses); end
        n_cmp++;
        if (obs.size() != 2) begin n_err++; $display("FAIL mask_count: got %0d want 2", obs.size()); end
        else begin
            n_cmp++;
            if (pk(obs[0]) !== pk(e0)) begin
                n_err++; $display("FAIL mask_word0: got %h want %h", pk(obs[0]), pk(e0));
            end
            n_cmp++;
            if (pk(obs[1]) !== pk(e1)) begin
                n_err++; $display("FAIL mask_word1: got %h want %h", pk(obs[1]), pk(e1));
            end
        end
    endtask

    task automatic test_overflow();
        logic [K-1:0] t0[17], t1[17];
        int hi, pulses;
        beat_t e;
        obs.delete();
        gt_seq_m = '0;
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i == 15) begin
                n_cmp++;
                if (gt_full !== 1'b0) begin n_err++; $display("FAIL full_early: got %b want 0", gt_full); end
            end
            if (i == 16) begin
                n_cmp++;
                if (gt_full !== 1'b1) begin n_err++; $display("FAIL full_at16: got %b want 1", gt_full); end
            end
            t0[i] = rnd_k(); t1[i] = rnd_k();
            gt_t0 = t0[i]; gt_t1 = t1[i]; gt_wr = 1'b1;
            fin = (i == 5);
            tick();
        end
        gt_wr = 1'b0; fin = 1'b0;
        n_cmp++;
        if ({overflow, gt_full} !== 2'b11) begin
            n_err++; $display("FAIL overflow_set: got %b want 11", {overflow, gt_full});
        end
        send_keys(rnd_k(), rnd_k(), hi);
        wait_done(80, pulses);
        n_cmp++;
        if (pulses != 1) begin n_err++; $display("FAIL ovf_done: got %0d pulses want 1", pulses); end
        n_cmp++;
        if (obs.size() != 17) begin n_err++; $display("FAIL ovf_count: got %0d want 17", obs.size()); end
        else begin
            n_cmp++;
            if (obs[0].tag !== 3'b001) begin n_err++; $display("FAIL ovf_keytag: got %b want 001", obs[0].tag); end
            for (int i = 0; i < 16; i++) begin
                e.tag = 3'b010; e.i0 = S'(2 * i); e.i1 = S'(2 * i + 1); e.d0 = t0[i]; e.d1 = t1[i];
                n_cmp++;
                if (pk(obs[i+1]) !== pk(e)) begin
                    n_err++; $display("FAIL ovf_beat%0d: got %h want %h", i, pk(obs[i+1]), pk(e));
                end
            end
        end
        n_cmp++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_reset_midrun();
        logic [2*S+8:0] got, want;
        logic [K-1:0] n0, n1;
        int hi, pulses;
        beat_t e;
        want = {1'b0, 3'b000, ONES, ONES, 5'b00000};
        obs.delete();
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        send_keys(rnd_k(), rnd_k(), hi);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            gt_t0 = rnd_k(); gt_t1 = rnd_k(); gt_wr = 1'b1; tick();
        end
        gt_wr = 1'b0;
        tick();
        #3 rst = 1'b0;
        #1;
        got = {out_valid, tag, index0, index1, done, overflow, key_ready, lbl_ready, gt_full};
        n_cmp++;
        if (got !== want) begin n_err++; $display("FAIL midrst_ctrl: got %h want %h", got, want); end
        n_cmp++;
        if ({data0, data1} !== '0) begin
            n_err++; $display("FAIL midrst_data: got %h %h want 0", data0, data1);
        end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        obs.delete();
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        send_keys(rnd_k(), rnd_k(), hi);
        n0 = rnd_k(); n1 = rnd_k();
        gt_t0 = n0; gt_t1 = n1; gt_wr = 1'b1; tick(); gt_wr = 1'b0;
        repeat (5) tick();
        e.tag = 3'b010; e.i0 = S'(0); e.i1 = S'(1); e.d0 = n0; e.d1 = n1;
        n_cmp++;
        if (obs.size() != 2) begin n_err++; $display("FAIL midrst_count: got %0d want 2", obs.size()); end
        else begin
            n_cmp++;
            if (pk(obs[1]) !== pk(e)) begin
                n_err++; $display("FAIL midrst_gt: got %h want %h", pk(obs[1]), pk(e));
            end
        end
        fin = 1'b1; tick(); fin = 1'b0;
        wait_done(20, pulses);
    endtask

    task automatic test_random();
        beat_t exp_lbl[$], exp_gt[$], got_lbl[$], got_gt[$], got_mask[$];
        bit    bits[$];
        beat_t e;
        bit    hold, acc, gen;
        int    hi, pulses, nw;
        logic [W-1:0] wd;
        obs.delete();
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        send_keys(rnd_k(), rnd_k(), hi);
        obs.delete();
        hold = 0;
        for (int c = 0; c < 700; c++) begin
            gen = (c < 500);
            acc = 0;
            out_ready = ($urandom_range(3) != 0);
            if (!hold && gen && $urandom_range(2) == 0) begin
                lbl_valid = 2'($urandom_range(1, 3));
                lbl_index0 = S'($urandom); lbl_index1 = S'($urandom);
                lbl_data0 = rnd_k(); lbl_data1 = rnd_k();
                hold = 1;
            end
            gt_wr = gen && !gt_full && ($urandom_range(2) == 0);
            gt_t0 = rnd_k(); gt_t1 = rnd_k();
            mask_valid = gen && ($urandom_range(1) == 1);
            mask_bit = ($urandom_range(1) == 1);
            @(negedge clk);
            if (lbl_ready) begin
                e.tag = {1'b1, lbl_valid};
                e.i0 = lbl_valid[0] ? lbl_index0 : ONES;
                e.i1 = lbl_valid[1] ? lbl_index1 : ONES;
                e.d0 = lbl_valid[0] ? lbl_data0 : '0;
                e.d1 = lbl_valid[1] ? lbl_data1 : '0;
                exp_lbl.push_back(e);
                acc = 1;
            end
            if (gt_wr) begin
                e.tag = 3'b010; e.i0 = S'(2 * exp_gt.size()); e.i1 = S'(2 * exp_gt.size() + 1);
                e.d0 = gt_t0; e.d1 = gt_t1;
                exp_gt.push_back(e);
            end
            if (mask_valid) bits.push_back(mask_bit);
            tick();
            if (acc) begin lbl_valid = 2'b00; hold = 0; end
            if (!gen && !hold) break;
        end
        lbl_valid = 2'b00; gt_wr = 1'b0; mask_valid = 1'b0;
        fin = 1'b1; tick(); fin = 1'b0;
        out_ready = 1'b1;
        wait_done(400, pulses);
        n_cmp++;
        if (pulses != 1) begin n_err++; $display("FAIL rnd_done: got %0d pulses want 1", pulses); end
        foreach (obs[i]) begin
            if (obs[i].tag[2]) got_lbl.push_back(obs[i]);
            else if (obs[i].tag == 3'b010) got_gt.push_back(obs[i]);
            else got_mask.push_back(obs[i]);
        end
        nw = (bits.size() + W - 1) / W;
        n_cmp++;
        if (got_lbl.size() != exp_lbl.size()) begin
            n_err++; $display("FAIL rnd_lbl_count: got %0d want %0d", got_lbl.size(), exp_lbl.size());
        end
        n_cmp++;
        if (got_gt.size() != exp_gt.size()) begin
            n_err++; $display("FAIL rnd_gt_count: got %0d want %0d", got_gt.size(), exp_gt.size());
        end
        n_cmp++;
        if (got_mask.size() != nw) begin
            n_err++; $display("FAIL rnd_mask_count: got %0d want %0d", got_mask.size(), nw);
        end
        for (int i = 0; i < exp_lbl.size() && i < got_lbl.size(); i++) begin
            n_cmp++;
            if (pk(got_lbl[i]) !== pk(exp_lbl[i])) begin
                n_err++; $display("FAIL rnd_lbl%0d: got %h want %h", i, pk(got_lbl[i]), pk(exp_lbl[i]));
            end
        end
        for (int i = 0; i < exp_gt.size() && i < got_gt.size(); i++) begin
            n_cmp++;
            if (pk(got_gt[i]) !== pk(exp_gt[i])) begin
                n_err++; $display("FAIL rnd_gt%0d: got %h want %h", i, pk(got_gt[i]), pk(exp_gt[i]));
            end
        end
        for (int w = 0; w < nw && w < got_mask.size(); w++) begin
            wd = '0;
            for (int j = 0; j < W && (w * W + j) < bits.size(); j++) wd[j] = bits[w * W + j];
            e.tag = 3'b011; e.i0 = S'(w); e.i1 = ONES; e.d0 = wd[K-1:0]; e.d1 = wd[W-1:K];
            n_cmp++;
            if (pk(got_mask[w]) !== pk(e)) begin
                n_err++; $display("FAIL rnd_mask%0d: got %h want %h", w, pk(got_mask[w]), pk(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_keys();
        test_gt_stall();
        test_label_priority();
        test_mask();
        test_overflow();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
